cgra_exec_sequencer: RTL and testbench

Parametrised control sequencer for the CGRA accelerator, sitting between the CSR block and the data-movement state machines. It accepts configuration-load and execute commands, including a chained load-then-execute in one command. It issues per-channel launch pulses to up to N_IN input and N_OUT output streamers, collects per-channel completion, and automatically re-launches execution for a programmable iteration count. It keeps saturating performance counters for configuration, execution and stall cycles.

---
 rtl/cgra_exec_sequencer_if.sv | 51 +++++
 rtl/cgra_exec_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cgra_exec_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_exec_sequencer_if.sv
// Command, launch, completion and counter signals between the CGRA
// control plane (master) and the execution sequencer (slave).
interface cgra_exec_sequencer_if #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int CNT_W  = 32,
   parameter int ITER_W = 16
);
   logic              load_configuration_i;
   logic              start_execution_i;
   logic              abort_i;
   logic [N_IN-1:0]   in_mask_i;
   logic [N_OUT-1:0]  out_mask_i;
   logic [ITER_W-1:0] iterations_i;
   logic              data_config_done_i;
   logic [N_OUT-1:0]  data_output_done_i;
   logic              data_read_stall_i;
   logic              data_write_stall_i;
   logic              execute_config_o;
   logic [N_IN-1:0]   execute_input_o;
   logic [N_OUT-1:0]  execute_output_o;
   logic              busy_o;
   logic              done_o;
   logic              abort_o;
   logic [ITER_W-1:0] iter_count_o;
   logic [CNT_W-1:0]  cycle_count_config_o;
   logic [CNT_W-1:0]  cycle_count_exec_o;
   logic [CNT_W-1:0]  cycle_count_stall_o;

   modport master (
      output load_configuration_i, start_execution_i, abort_i,
      output in_mask_i, out_mask_i, iterations_i,
      output data_config_done_i, data_output_done_i,
      output data_read_stall_i, data_write_stall_i,
      input  execute_config_o, execute_input_o, execute_output_o,
      input  busy_o, done_o, abort_o, iter_count_o,
      input  cycle_count_config_o, cycle_count_exec_o,
      input  cycle_count_stall_o
   );

   modport slave (
      input  load_configuration_i, start_execution_i, abort_i,
      input  in_mask_i, out_mask_i, iterations_i,
      input  data_config_done_i, data_output_done_i,
      input  data_read_stall_i, data_write_stall_i,
      output execute_config_o, execute_input_o, execute_output_o,
      output busy_o, done_o, abort_o, iter_count_o,
      output cycle_count_config_o, cycle_count_exec_o,
      output cycle_count_stall_o
   );
endinterface

// File: rtl/cgra_exec_sequencer.sv
// CGRA execution sequencer: launches config/exec streamers, tracks
// per-channel completion, repeats iterations, keeps saturating counters.
module cgra_exec_sequencer #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int CNT_W  = 32,
   parameter int ITER_W = 16
) (
   input logic                  clk_i,
   input logic                  rst_i,
   cgra_exec_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CONFIG, EXEC, FINISH} state_e;

   state_e            state_q, state_d;
   logic              chain_q, chain_d;
   logic [N_IN-1:0]   in_mask_q, in_mask_d;
   logic [N_IN-1:0]   in_pulse_q, in_pulse_d;
   logic [N_OUT-1:0]  out_mask_q, out_mask_d;
   logic [N_OUT-1:0]  out_pulse_q, out_pulse_d;
   logic [N_OUT-1:0]  seen_q, seen_d;
   logic [ITER_W-1:0] tgt_q, tgt_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              cfg_pulse_q, cfg_pulse_d;
   logic              abort_q, abort_d;
   logic [CNT_W-1:0]  cnt_cfg_q, cnt_cfg_d;
   logic [CNT_W-1:0]  cnt_exe_q, cnt_exe_d;
   logic [CNT_W-1:0]  cnt_stl_q, cnt_stl_d;
   logic              clr, launch, complete;
   logic [N_OUT-1:0]  done_m;

   assign done_m   = (seen_q | bus.data_output_done_i) & out_mask_q;
   assign complete = (done_m == out_mask_q);

   always_comb begin
      state_d     = state_q;
      chain_d     = chain_q;
      in_mask_d   = in_mask_q;
      out_mask_d  = out_mask_q;
      tgt_d       = tgt_q;
      iter_d      = iter_q;
      seen_d      = seen_q;
      cfg_pulse_d = 1'b0;
      in_pulse_d  = '0;
      out_pulse_d = '0;
      abort_d     = 1'b0;
      clr         = 1'b0;
      launch      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.load_configuration_i || bus.start_execution_i) begin
               clr        = 1'b1;
               iter_d     = '0;
               in_mask_d  = bus.in_mask_i;
               out_mask_d = bus.out_mask_i;
               tgt_d      = (bus.iterations_i == '0) ? ITER_W'(1)
                                                     : bus.iterations_i;
            end
            if (bus.load_configuration_i) begin
               state_d     = CONFIG;
               cfg_pulse_d = 1'b1;
               chain_d     = bus.start_execution_i;
            end else if (bus.start_execution_i) begin
               state_d = EXEC;
               launch  = 1'b1;
            end
         end
         CONFIG: begin
            if (bus.abort_i) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (bus.data_config_done_i) begin
               state_d = chain_q ? EXEC : FINISH;
               launch  = chain_q;
            end
         end
         EXEC: begin
            if (bus.abort_i) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else begin
               seen_d = done_m;
               if (complete) begin
                  iter_d = iter_q + ITER_W'(1);
                  if (iter_d < tgt_q) launch = 1'b1;
                  else state_d = FINISH;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            abort_d = bus.abort_i;
         end
      endcase
      // Launches always use the mask that will be held for this command.
      if (launch) begin
         in_pulse_d  = in_mask_d;
         out_pulse_d = out_mask_d;
         seen_d      = '0;
      end
   end

   always_comb begin
      cnt_cfg_d = cnt_cfg_q;
      cnt_exe_d = cnt_exe_q;
      cnt_stl_d = cnt_stl_q;
      if (clr) begin
         cnt_cfg_d = '0;
         cnt_exe_d = '0;
         cnt_stl_d = '0;
      end else begin
         if (state_q == CONFIG && !(&cnt_cfg_q))
            cnt_cfg_d = cnt_cfg_q + CNT_W'(1);
         if (state_q == EXEC && !(&cnt_exe_q))
            cnt_exe_d = cnt_exe_q + CNT_W'(1);
         if (state_q == EXEC && !(&cnt_stl_q) &&
             (bus.data_read_stall_i || bus.data_write_stall_i))
            cnt_stl_d = cnt_stl_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         chain_q     <= 1'b0;
         in_mask_q   <= '0;
         out_mask_q  <= '0;
         in_pulse_q  <= '0;
         out_pulse_q <= '0;
         seen_q      <= '0;
         tgt_q       <= '0;
         iter_q      <= '0;
         cfg_pulse_q <= 1'b0;
         abort_q     <= 1'b0;
         cnt_cfg_q   <= '0;
         cnt_exe_q   <= '0;
         cnt_stl_q   <= '0;
      end else begin
         state_q     <= state_d;
         chain_q     <= chain_d;
         in_mask_q   <= in_mask_d;
         out_mask_q  <= out_mask_d;
         in_pulse_q  <= in_pulse_d;
         out_pulse_q <= out_pulse_d;
         seen_q      <= seen_d;
         tgt_q       <= tgt_d;
         iter_q      <= iter_d;
         cfg_pulse_q <= cfg_pulse_d;
         abort_q     <= abort_d;
         cnt_cfg_q   <= cnt_cfg_d;
         cnt_exe_q   <= cnt_exe_d;
         cnt_stl_q   <= cnt_stl_d;
      end
   end

   assign bus.execute_config_o     = cfg_pulse_q;
   assign bus.execute_input_o      = in_pulse_q;
   assign bus.execute_output_o     = out_pulse_q;
   assign bus.busy_o               = (state_q != IDLE);
   assign bus.done_o               = (state_q == FINISH);
   assign bus.abort_o              = abort_q;
   assign bus.iter_count_o         = iter_q;
   assign bus.cycle_count_config_o = cnt_cfg_q;
   assign bus.cycle_count_exec_o   = cnt_exe_q;
   assign bus.cycle_count_stall_o  = cnt_stl_q;
endmodule

// File: tb/tb_cgra_exec_sequencer.sv
// Directed bench for cgra_exec_sequencer (4-bit counters to reach
// saturation quickly).
module tb_cgra_exec_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   int n_cfg, n_in, n_out, n_done, n_abort, n_busy;

   always #5 clk = ~clk;

   cgra_exec_sequencer_if #(
      .N_IN(4), .N_OUT(4), .CNT_W(4), .ITER_W(16)
   ) bus ();

   cgra_exec_sequencer #(
      .N_IN(4), .N_OUT(4), .CNT_W(4), .ITER_W(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_counts();
      n_cfg = 0; n_in = 0; n_out = 0;
      n_done = 0; n_abort = 0; n_busy = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.execute_config_o) n_cfg++;
      if (bus.execute_input_o != 4'b0) n_in++;
      if (bus.execute_output_o != 4'b0) n_out++;
      if (bus.done_o) n_done++;
      if (bus.abort_o) n_abort++;
      if (bus.busy_o) n_busy++;
   endtask

   task automatic idle_inputs();
      bus.load_configuration_i = 1'b0;
      bus.start_execution_i    = 1'b0;
      bus.abort_i              = 1'b0;
      bus.data_config_done_i   = 1'b0;
      bus.data_output_done_i   = 4'b0;
      bus.data_read_stall_i    = 1'b0;
      bus.data_write_stall_i   = 1'b0;
   endtask

   initial begin
      idle_inputs();
      bus.in_mask_i    = 4'b0;
      bus.out_mask_i   = 4'b0;
      bus.iterations_i = 16'd0;
      clr_counts();
      #12;
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_abort", bus.abort_o, 0);
      chk("rst_pulses", {bus.execute_config_o, bus.execute_input_o,
                         bus.execute_output_o}, 0);
      chk("rst_cnts", {bus.cycle_count_config_o, bus.cycle_count_exec_o,
                       bus.cycle_count_stall_o, bus.iter_count_o}, 0);
      rst = 1'b0;
      step();

      // single execute, dones staggered over four cycles
      clr_counts();
      bus.in_mask_i = 4'b0101; bus.out_mask_i = 4'b1111;
      bus.iterations_i = 16'd1; bus.start_execution_i = 1'b1;
      step();
      chk("t1_busy", bus.busy_o, 1);
      chk("t1_in", bus.execute_input_o, 4'b0101);
      chk("t1_out", bus.execute_output_o, 4'b1111);
      idle_inputs();
      bus.data_output_done_i = 4'b0001; step();
      bus.data_output_done_i = 4'b0000; step();
      bus.data_output_done_i = 4'b0010; step();
      bus.data_output_done_i = 4'b0100; step();
      chk("t1_nodone_early", bus.done_o, 0);
      bus.data_output_done_i = 4'b1000; step();
      bus.data_output_done_i = 4'b0000;
      chk("t1_done", bus.done_o, 1);
      chk("t1_exec_cnt", bus.cycle_count_exec_o, 5);
      chk("t1_iter", bus.iter_count_o, 1);
      step();
      chk("t1_idle", bus.busy_o, 0);
      chk("t1_launches", n_out, 1);
      chk("t1_ndone", n_done, 1);

      // chained load+execute, config done after 10 cycles
      clr_counts();
      bus.in_mask_i = 4'b1111; bus.out_mask_i = 4'b0011;
      bus.iterations_i = 16'd1;
      bus.load_configuration_i = 1'b1; bus.start_execution_i = 1'b1;
      step();
      idle_inputs();
      chk("t2_cfg_pulse", bus.execute_config_o, 1);
      chk("t2_no_exec", bus.execute_output_o, 0);
      chk("t2_cnt_clr", bus.cycle_count_exec_o, 0);
      for (int i = 1; i < 10; i++) begin
         bus.data_output_done_i = (i == 5) ? 4'b0011 : 4'b0000;
         step();
      end
      bus.data_output_done_i = 4'b0;
      bus.data_config_done_i = 1'b1;
      step();
      bus.data_config_done_i = 1'b0;
      chk("t2_cfg_cnt", bus.cycle_count_config_o, 10);
      chk("t2_in", bus.execute_input_o, 4'b1111);
      chk("t2_out", bus.execute_output_o, 4'b0011);
      chk("t2_not_done", bus.done_o, 0);
      bus.data_output_done_i = 4'b0011; step();
      bus.data_output_done_i = 4'b0;
      chk("t2_done", bus.done_o, 1);
      chk("t2_exec_cnt", bus.cycle_count_exec_o, 1);
      step();
      chk("t2_ncfg", n_cfg, 1);
      chk("t2_nout", n_out, 1);
      chk("t2_ndone", n_done, 1);

      // three iterations
      clr_counts();
      bus.in_mask_i = 4'b1000; bus.out_mask_i = 4'b0011;
      bus.iterations_i = 16'd3; bus.start_execution_i = 1'b1;
      step();
      idle_inputs();
      chk("t3_iter0", bus.iter_count_o, 0);
      bus.data_output_done_i = 4'b0011; step();
      chk("t3_relaunch", bus.execute_output_o, 4'b0011);
      chk("t3_iter1", bus.iter_count_o, 1);
      step();
      bus.data_output_done_i = 4'b0;
      chk("t3_iter2", bus.iter_count_o, 2);
      step();
      bus.data_output_done_i = 4'b0011; step();
      bus.data_output_done_i = 4'b0;
      chk("t3_done", bus.done_o, 1);
      chk("t3_iter3", bus.iter_count_o, 3);
      chk("t3_exec_cnt", bus.cycle_count_exec_o, 4);
      step();
      chk("t3_nout", n_out, 3);
      chk("t3_nin", n_in, 3);
      chk("t3_ndone", n_done, 1);
      chk("t3_iter_hold", bus.iter_count_o, 3);

      // abort in EXEC on fifth cycle
      clr_counts();
      bus.abort_i = 1'b1; step();
      bus.abort_i = 1'b0;
      chk("t4_idle_abort_ign", bus.abort_o, 0);
      bus.out_mask_i = 4'b1111; bus.iterations_i = 16'd1;
      bus.start_execution_i = 1'b1;
      step();
      idle_inputs();
      for (int i = 0; i < 4; i++) step();
      bus.abort_i = 1'b1; step();
      bus.abort_i = 1'b0;
      chk("t4_abort", bus.abort_o, 1);
      chk("t4_busy_low", bus.busy_o, 0);
      chk("t4_no_done", bus.done_o, 0);
      step();
      chk("t4_abort_pulse", bus.abort_o, 0);
      chk("t4_busy_low2", bus.busy_o, 0);
      chk("t4_exec_hold", bus.cycle_count_exec_o, 5);
      chk("t4_ndone", n_done, 0);

      // zero mask, iterations 0 -> one pass, busy for 2 cycles
      clr_counts();
      bus.in_mask_i = 4'b0011; bus.out_mask_i = 4'b0000;
      bus.iterations_i = 16'd0; bus.start_execution_i = 1'b1;
      step();
      idle_inputs();
      chk("t4b_cnt_clr", bus.cycle_count_exec_o, 0);
      chk("t4b_in", bus.execute_input_o, 4'b0011);
      step();
      chk("t4b_done", bus.done_o, 1);
      chk("t4b_iter", bus.iter_count_o, 1);
      step(); step();
      chk("t4b_busy_cycles", n_busy, 2);

      // stall saturation with 4-bit counters
      clr_counts();
      bus.in_mask_i = 4'b0001; bus.out_mask_i = 4'b0001;
      bus.iterations_i = 16'd1; bus.start_execution_i = 1'b1;
      step();
      idle_inputs();
      bus.data_read_stall_i = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("t5_stall10", bus.cycle_count_stall_o, 10);
      bus.data_read_stall_i = 1'b0; bus.data_write_stall_i = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("t5_stall_sat", bus.cycle_count_stall_o, 15);
      chk("t5_exec_sat", bus.cycle_count_exec_o, 15);
      bus.data_write_stall_i = 1'b0;
      bus.data_output_done_i = 4'b0001; step();
      bus.data_output_done_i = 4'b0;
      chk("t5_done", bus.done_o, 1);
      chk("t5_stall_hold", bus.cycle_count_stall_o, 15);
      step();

      // commands while busy and unmasked done; abort in FINISH
      clr_counts();
      bus.in_mask_i = 4'b0001; bus.out_mask_i = 4'b0001;
      bus.iterations_i = 16'd1; bus.start_execution_i = 1'b1;
      step();
      idle_inputs();
      step();
      bus.start_execution_i = 1'b1; bus.load_configuration_i = 1'b1;
      bus.data_output_done_i = 4'b1110;
      step();
      idle_inputs();
      chk("t6_no_launch", bus.execute_output_o, 0);
      chk("t6_no_cfg", bus.execute_config_o, 0);
      chk("t6_not_done", bus.done_o, 0);
      chk("t6_busy", bus.busy_o, 1);
      bus.data_output_done_i = 4'b0001; step();
      bus.data_output_done_i = 4'b0;
      chk("t6_done", bus.done_o, 1);
      bus.abort_i = 1'b1; step();
      bus.abort_i = 1'b0;
      chk("t6_fin_abort", bus.abort_o, 1);
      chk("t6_nout", n_out, 1);
      chk("t6_ncfg", n_cfg, 0);
      chk("t6_ndone", n_done, 1);

      // reset mid-operation
      bus.out_mask_i = 4'b0001; bus.start_execution_i = 1'b1;
      step();
      idle_inputs();
      step();
      #2 rst = 1'b1;
      #1;
      chk("t7_busy", bus.busy_o, 0);
      chk("t7_done", bus.done_o, 0);
      chk("t7_cnt", bus.cycle_count_exec_o, 0);
      step();
      rst = 1'b0;
      chk("t7_idle", bus.busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
